// File: rtl/pipeline_scoreboard.sv
// Hazard unit with a one-entry long-op scoreboard: load-use, busy-register and structural stalls plus redirect flushes.
// Latency: stall/flush are combinational (0 cycles); scoreboard state and counters update on the next edge.
module pipeline_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       rs1_id,
    input  logic [AW-1:0]       rs2_id,
    input  logic                rs1_used_id,
    input  logic                rs2_used_id,
    input  logic                long_op_id,
    input  logic                jal_id,
    input  logic [AW-1:0]       rd_ex,
    input  logic                memread_ex,
    input  logic                regwrite_ex,
    input  logic                long_issue_ex,
    input  logic                redirect_ex,
    input  logic                long_done,
    output logic                stall_if,
    output logic                stall_id,
    output logic                flush_if,
    output logic                flush_id,
    output logic                flush_ex,
    output logic                long_busy,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    redirect_count,
    output logic                err
);

    if (2**AW != NUM_REGS) begin : g_bad_cfg
        $error("pipeline_scoreboard: 2**AW must equal NUM_REGS");
    end

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                long_busy_q, long_busy_d;
    logic [AW-1:0]       long_rd_q, long_rd_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    redir_cnt_q, redir_cnt_d;
    logic                err_q, err_d;

    logic ld_use, rs1_wait, rs2_wait, sb_hit, struct_hz, hz;
    logic issue_acc, issue_ok, done_ok;

    // A source whose pending write lands this very cycle is readable through the write-through regfile.
    always_comb begin
        ld_use    = memread_ex & regwrite_ex & (rd_ex != '0) &
                    ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));
        rs1_wait  = rs1_used_id & (rs1_id != '0) & busy_q[rs1_id] &
                    ~(long_done & (rs1_id == long_rd_q));
        rs2_wait  = rs2_used_id & (rs2_id != '0) & busy_q[rs2_id] &
                    ~(long_done & (rs2_id == long_rd_q));
        sb_hit    = rs1_wait | rs2_wait;
        struct_hz = long_op_id & long_busy_q & ~long_done;
        hz        = ld_use | sb_hit | struct_hz;
    end

    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (rst_n) begin
            if (redirect_ex) begin
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (hz) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end else if (jal_id) begin
                flush_if = 1'b1;
            end
        end
    end

    // Clear-before-set lets a same-cycle done and reissue to the same rd leave that register busy.
    always_comb begin
        issue_acc   = long_issue_ex & ~redirect_ex;
        done_ok     = long_done & long_busy_q;
        issue_ok    = issue_acc & (~long_busy_q | long_done);
        err_d       = err_q | (issue_acc & long_busy_q & ~long_done) | (long_done & ~long_busy_q);
        busy_d      = busy_q;
        long_busy_d = long_busy_q;
        long_rd_d   = long_rd_q;
        if (done_ok) begin
            busy_d[long_rd_q] = 1'b0;
            long_busy_d       = 1'b0;
        end
        if (issue_ok) begin
            long_busy_d = 1'b1;
            long_rd_d   = rd_ex;
            if (regwrite_ex && (rd_ex != '0)) begin
                busy_d[rd_ex] = 1'b1;
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (hz && !redirect_ex && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        redir_cnt_d = redir_cnt_q;
        if (redirect_ex && (redir_cnt_q != '1)) begin
            redir_cnt_d = redir_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            long_busy_q <= 1'b0;
            long_rd_q   <= '0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            long_busy_q <= long_busy_d;
            long_rd_q   <= long_rd_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        busy_vec    = busy_q;
        busy_vec[0] = 1'b0;
    end

    assign long_busy      = long_busy_q;
    assign stall_count    = stall_cnt_q;
    assign redirect_count = redir_cnt_q;
    assign err            = err_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Bench for pipeline_scoreboard: priority table, hand-written multi-cycle sequences, and random traffic
// checked against a set-based reference model of the hazard rules.
module tb_pipeline_scoreboard;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] rs1_id, rs2_id, rd_ex;
    logic rs1_used_id, rs2_used_id, long_op_id, jal_id;
    logic memread_ex, regwrite_ex, long_issue_ex, redirect_ex, long_done;
    logic stall_if, stall_id, flush_if, flush_id, flush_ex, long_busy, err;
    logic [NR-1:0] busy_vec;
    logic [CW-1:0] stall_count, redirect_count;

    pipeline_scoreboard #(.NUM_REGS(NR), .AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .long_op_id(long_op_id), .jal_id(jal_id),
        .rd_ex(rd_ex), .memread_ex(memread_ex), .regwrite_ex(regwrite_ex),
        .long_issue_ex(long_issue_ex), .redirect_ex(redirect_ex), .long_done(long_done),
        .stall_if(stall_if), .stall_id(stall_id),
        .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
        .long_busy(long_busy), .busy_vec(busy_vec),
        .stall_count(stall_count), .redirect_count(redirect_count), .err(err)
    );

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1, u2, lop, jal;
        logic [4:0] rd;
        logic       mr, rw, li, rdr, ld;
    } vin_t;

    typedef struct {
        vin_t       v;
        logic [4:0] ctrl;   // {stall_if, stall_id, flush_if, flush_id, flush_ex}
        string      name;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: set of pending registers plus the single outstanding long op.
    bit m_pend[NR];
    bit m_lbusy;
    int m_lrd;
    bit m_err;
    int m_sc, m_rc;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i] = m_pend[i];
        return r;
    endfunction

    function automatic bit waits(input logic [4:0] r, input logic u, input logic ld);
        return u && (r != 0) && m_pend[r] && !(ld && (int'(r) == m_lrd));
    endfunction

    function automatic logic [4:0] model_ctrl(input vin_t v);
        bit lu, sb, st;
        lu = v.mr && v.rw && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        sb = waits(v.rs1, v.u1, v.ld) || waits(v.rs2, v.u2, v.ld);
        st = v.lop && m_lbusy && !v.ld;
        if (v.rdr) return 5'b00110;
        if (lu || sb || st) return 5'b11001;
        if (v.jal) return 5'b00100;
        return 5'b00000;
    endfunction

    task automatic model_update(input vin_t v);
        logic [4:0] c;
        bit issue;
        c = model_ctrl(v);
        issue = v.li && !v.rdr;
        if (c[4] && m_sc < SAT) m_sc++;
        if (v.rdr && m_rc < SAT) m_rc++;
        if (v.ld && !m_lbusy) m_err = 1'b1;
        if (issue && m_lbusy && !v.ld) begin
            m_err = 1'b1;
        end else begin
            if (v.ld && m_lbusy) begin
                m_pend[m_lrd] = 1'b0;
                m_lbusy = 1'b0;
            end
            if (issue) begin
                m_lbusy = 1'b1;
                m_lrd = int'(v.rd);
                if (v.rw && v.rd != 0) m_pend[v.rd] = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        m_lbusy = 1'b0; m_lrd = 0; m_err = 1'b0; m_sc = 0; m_rc = 0;
    endtask

    task automatic drive(input vin_t v);
        rs1_id = v.rs1; rs2_id = v.rs2; rs1_used_id = v.u1; rs2_used_id = v.u2;
        long_op_id = v.lop; jal_id = v.jal; rd_ex = v.rd; memread_ex = v.mr;
        regwrite_ex = v.rw; long_issue_ex = v.li; redirect_ex = v.rdr; long_done = v.ld;
    endtask

    function automatic logic [4:0] ctrl_now();
        return {stall_if, stall_id, flush_if, flush_id, flush_ex};
    endfunction

    // Called 1 time unit after a rising edge; samples mid-cycle, then advances one clock.
    task automatic step(input vin_t v, input string tag);
        drive(v);
        #2;
        chk({tag, ":ctrl"}, 32'(ctrl_now()), 32'(model_ctrl(v)));
        chk({tag, ":busy_vec"}, busy_vec, model_vec());
        chk({tag, ":long_busy"}, 32'(long_busy), 32'(m_lbusy));
        chk({tag, ":stall_count"}, 32'(stall_count), 32'(m_sc));
        chk({tag, ":redirect_count"}, 32'(redirect_count), 32'(m_rc));
        chk({tag, ":err"}, 32'(err), 32'(m_err));
        @(posedge clk);
        model_update(v);
        #1;
    endtask

    task automatic xstep(input vin_t v, input string tag, input logic [4:0] want);
        drive(v);
        #1;
        chk({tag, ":expect_ctrl"}, 32'(ctrl_now()), 32'(want));
        step(v, tag);
    endtask

    // Reset is checked before any clock edge to prove it acts asynchronously.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk({tag, ":rst_ctrl"}, 32'(ctrl_now()), 32'd0);
        chk({tag, ":rst_busy_vec"}, busy_vec, 32'd0);
        chk({tag, ":rst_long_busy"}, 32'(long_busy), 32'd0);
        chk({tag, ":rst_counts"}, {16'(stall_count), 16'(redirect_count)}, 32'd0);
        chk({tag, ":rst_err"}, 32'(err), 32'd0);
        model_reset();
        drive('0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];
    vin_t v, lu;
    int sc0, rc0;

    initial begin
        v = '0;
        tbl[0].v = v;                                                               tbl[0].ctrl = 5'b00000; tbl[0].name = "idle";
        v = '0; v.mr = 1; v.rw = 1; v.rd = 5; v.rs2 = 5; v.u2 = 1;                  tbl[1].v = v; tbl[1].ctrl = 5'b11001; tbl[1].name = "ld_use_rs2";
        v = '0; v.mr = 1; v.rw = 1; v.rd = 0; v.rs1 = 0; v.u1 = 1;                  tbl[2].v = v; tbl[2].ctrl = 5'b00000; tbl[2].name = "ld_use_x0";
        v = '0; v.mr = 1; v.rw = 1; v.rd = 6; v.rs1 = 6; v.u1 = 0;                  tbl[3].v = v; tbl[3].ctrl = 5'b00000; tbl[3].name = "ld_use_unused";
        v = '0; v.mr = 1; v.rw = 0; v.rd = 6; v.rs1 = 6; v.u1 = 1;                  tbl[4].v = v; tbl[4].ctrl = 5'b00000; tbl[4].name = "load_no_wb";
        v = '0; v.jal = 1;                                                          tbl[5].v = v; tbl[5].ctrl = 5'b00100; tbl[5].name = "jal";
        v = '0; v.mr = 1; v.rw = 1; v.rd = 5; v.rs2 = 5; v.u2 = 1; v.jal = 1; v.rdr = 1; tbl[6].v = v; tbl[6].ctrl = 5'b00110; tbl[6].name = "redirect_wins";
        v = '0; v.mr = 1; v.rw = 1; v.rd = 9; v.rs1 = 9; v.u1 = 1; v.jal = 1;       tbl[7].v = v; tbl[7].ctrl = 5'b11001; tbl[7].name = "hz_over_jal";
        v = '0; v.mr = 1; v.rw = 1; v.rd = 12; v.rs1 = 12; v.u1 = 1;                tbl[8].v = v; tbl[8].ctrl = 5'b11001; tbl[8].name = "ld_use_rs1";
        v = '0; v.lop = 1;                                                          tbl[9].v = v; tbl[9].ctrl = 5'b00000; tbl[9].name = "long_op_idle_unit";

        lu = '0; lu.mr = 1; lu.rw = 1; lu.rd = 5; lu.rs2 = 5; lu.u2 = 1;
        model_reset();
        drive(lu);
        #1;
        do_reset("init");

        // Load-use from reset: counter goes 0 -> 1.
        xstep(lu, "ld_use", 5'b11001);
        chk("ld_use:stall_count_1", 32'(stall_count), 32'd1);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v);
            #1;
            chk({"tbl:", tbl[i].name}, 32'(ctrl_now()), 32'(tbl[i].ctrl));
            step(tbl[i].v, tbl[i].name);
        end

        // Priority: redirect with load-use and jal leaves stall_count and bumps redirect_count.
        sc0 = int'(stall_count); rc0 = int'(redirect_count);
        v = lu; v.jal = 1; v.rdr = 1;
        xstep(v, "prio", 5'b00110);
        chk("prio:stall_count_same", 32'(stall_count), 32'(sc0));
        chk("prio:redirect_count_inc", 32'(redirect_count), 32'(rc0 + 1));

        // Scoreboard hit on rd=7: three stall cycles, none in the done cycle.
        v = '0; v.li = 1; v.rw = 1; v.rd = 7;
        step(v, "sb_issue");
        chk("sb:busy7_set", 32'(busy_vec[7]), 32'd1);
        v = '0; v.rs1 = 7; v.u1 = 1;
        for (int i = 0; i < 3; i++) xstep(v, "sb_wait", 5'b11001);
        v.ld = 1;
        xstep(v, "sb_done", 5'b00000);
        chk("sb:busy7_clear", 32'(busy_vec[7]), 32'd0);
        chk("sb:long_busy_clear", 32'(long_busy), 32'd0);

        // Structural hazard, then done of rd=3 coincides with issue of rd=9.
        v = '0; v.li = 1; v.rw = 1; v.rd = 3;
        step(v, "st_issue3");
        v = '0; v.lop = 1;
        xstep(v, "st_wait", 5'b11001);
        xstep(v, "st_wait", 5'b11001);
        v = '0; v.lop = 1; v.ld = 1; v.li = 1; v.rw = 1; v.rd = 9;
        xstep(v, "st_done_issue", 5'b00000);
        chk("st:busy3_clear", 32'(busy_vec[3]), 32'd0);
        chk("st:busy9_set", 32'(busy_vec[9]), 32'd1);
        chk("st:long_busy_kept", 32'(long_busy), 32'd1);
        v = '0; v.ld = 1; v.li = 1; v.rw = 1; v.rd = 9;
        step(v, "st_same_rd");
        chk("st:busy9_same_rd", 32'(busy_vec[9]), 32'd1);
        v = '0; v.ld = 1;
        step(v, "st_drain");
        step('0, "st_idle");

        // Issue while busy is an error and is dropped.
        do_reset("err1");
        v = '0; v.li = 1; v.rw = 1; v.rd = 6;
        step(v, "e_issue6");
        v.rd = 8;
        step(v, "e_issue8");
        chk("e:err_double_issue", 32'(err), 32'd1);
        chk("e:busy8_ignored", 32'(busy_vec[8]), 32'd0);
        v = '0; v.ld = 1;
        step(v, "e_done6");
        chk("e:busy6_clear", 32'(busy_vec[6]), 32'd0);

        // Spurious done, sticky err, reset mid-op, then done of the discarded op.
        do_reset("err2");
        v = '0; v.ld = 1;
        step(v, "e_spurious");
        step('0, "e_hold");
        step('0, "e_hold");
        chk("e:err_sticky", 32'(err), 32'd1);
        v = '0; v.li = 1; v.rw = 1; v.rd = 4;
        step(v, "e_issue4");
        drive(lu);
        do_reset("midop");
        v = '0; v.ld = 1;
        step(v, "e_done_after_rst");
        chk("e:err_after_rst_done", 32'(err), 32'd1);

        // Saturation of the 4-bit stall counter.
        do_reset("sat");
        for (int i = 0; i < 20; i++) step(lu, "sat");
        chk("sat:stall_count_15", 32'(stall_count), 32'd15);

        // Random traffic.
        do_reset("rnd");
        for (int n = 0; n < 400; n++) begin
            v.rs1 = 5'($urandom_range(0, 7));
            v.rs2 = 5'($urandom_range(0, 7));
            v.u1  = 1'($urandom_range(0, 1));
            v.u2  = 1'($urandom_range(0, 1));
            v.lop = ($urandom_range(0, 3) == 0);
            v.jal = ($urandom_range(0, 5) == 0);
            v.rd  = 5'($urandom_range(0, 7));
            v.mr  = ($urandom_range(0, 2) == 0);
            v.rw  = ($urandom_range(0, 3) != 0);
            v.li  = ($urandom_range(0, 4) == 0);
            v.rdr = ($urandom_range(0, 7) == 0);
            v.ld  = m_lbusy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            step(v, "rnd");
        end
        step('0, "final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_scoreboard.md
PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32: number of architectural registers; busy_vec width.
REQ-002 Parameter AW, default 5: register address width; the design SHALL satisfy 2**AW == NUM_REGS.
REQ-003 Parameter CNT_W, default 16: width of the stall and redirect counters.
REQ-004 Ports SHALL be as listed (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- rs1_id, rs2_id, in, AW: ID-stage source register addresses.
- rs1_used_id, rs2_used_id, in, 1: ID instruction reads that source.
- long_op_id, in, 1: ID instruction is a long-latency op (mul/div).
- jal_id, in, 1: ID instruction is JAL.
- rd_ex, in, AW: EX-stage destination register.
- memread_ex, regwrite_ex, in, 1: EX instruction is a load / writes a register.
- long_issue_ex, in, 1: EX instruction is issuing to the long-latency unit this cycle.
- redirect_ex, in, 1: EX branch taken or JALR.
- long_done, in, 1: one-cycle pulse; long unit writes its result this cycle.
- stall_if, out, 1: hold PC and IF/ID.
- stall_id, out, 1: hold the ID instruction.
- flush_if, flush_id, flush_ex, out, 1: squash IF/ID, ID/EX, or insert a bubble into EX.
- long_busy, out, 1: a long op is outstanding.
- busy_vec, out, NUM_REGS: per-register pending-write bits.
- stall_count, redirect_count, out, CNT_W: performance counters.
- err, out, 1: sticky protocol-error flag.

Function
REQ-005 ld_use SHALL be asserted when memread_ex & regwrite_ex & rd_ex!=0 and, for some source, rsN_used_id & rsN_id==rd_ex.
REQ-006 sb_hit SHALL be asserted when, for some source, rsN_used_id & rsN_id!=0 & busy_vec[rsN_id], and NOT (long_done & rsN_id==long_rd).
- The register file is write-through, so a read in the done cycle returns the new value.
REQ-007 struct_hz SHALL equal long_op_id & long_busy & ~long_done.
REQ-008 hz SHALL equal ld_use | sb_hit | struct_hz.
REQ-009 Output priority SHALL be redirect_ex > hz > jal_id > idle:
- redirect_ex: flush_if=1, flush_id=1; stalls=0, flush_ex=0.
- hz: stall_if=1, stall_id=1, flush_ex=1; flush_if=0, flush_id=0.
- jal_id: flush_if=1 only.
- idle: all 0.
REQ-010 Stall and flush outputs SHALL be combinational, with zero-cycle latency from their inputs.
REQ-011 An accepted issue SHALL be long_issue_ex & ~redirect_ex.
- Next edge: long_busy<=1, long_rd<=rd_ex.
- busy_vec[rd_ex]<=1 only when regwrite_ex & rd_ex!=0.
REQ-012 On long_done with long_busy=1, the next edge SHALL clear busy_vec[long_rd] and long_busy.
REQ-013 On simultaneous long_done and accepted issue, the clear SHALL apply first and the set second; if the register is the same, it ends busy and long_busy stays 1.
REQ-014 An accepted issue while long_busy=1 and ~long_done SHALL set err and SHALL be ignored (state unchanged).
REQ-015 long_done while long_busy=0 SHALL set err and SHALL change nothing else.
REQ-016 err SHALL remain set until reset.
REQ-017 busy_vec[0] SHALL always read 0.
REQ-018 stall_count SHALL increment on each edge where hz & ~redirect_ex, saturating at 2**CNT_W-1.
REQ-019 redirect_count SHALL increment on each edge where redirect_ex, saturating at 2**CNT_W-1.

Reset
REQ-020 While rst_n=0, the following SHALL all be forced to 0 immediately, independent of clk: busy_vec, long_busy, long_rd, stall_count, redirect_count, err, and every stall/flush output.
REQ-021 After rst_n deasserts, normal operation SHALL begin at the next rising clk edge.
REQ-022 Reset asserted mid-operation SHALL discard any outstanding long op; a later long_done SHALL then set err.

Verification
REQ-023 Load-use: memread_ex=1, regwrite_ex=1, rd_ex=5, rs2_id=5, rs2_used_id=1.
- Response: stall_if=stall_id=flush_ex=1; stall_count goes 0->1.
REQ-024 Scoreboard hit: issue a long op with rd_ex=7, then hold rs1_id=7 for 3 cycles, then pulse long_done.
- Response: stall for 3 cycles; no stall in the done cycle; busy_vec[7]=0 afterwards.
REQ-025 Structural hazard: long_busy=1, long_op_id=1.
- Response: stall each cycle until long_done.
- Then issue rd=9 in the same cycle as done of rd=3: busy_vec[3]=0, busy_vec[9]=1, long_busy=1.
REQ-026 Priority: redirect_ex=1 together with ld_use and jal_id.
- Response: flush_if=flush_id=1, stalls=0, stall_count unchanged, redirect_count +1.
REQ-027 Errors and reset:
- long_done with no op outstanding -> err=1 and stays 1.
- rst_n low mid-op -> err=0, busy_vec=0, counters=0 without waiting for a clock edge.
REQ-028 Saturation: with CNT_W=4, hold a hazard for 20 cycles.
- Response: stall_count stops at 15.
